credit_rx_buffer: RTL and testbench

Receiver end of a credit-based link. Buffers up to NumCredits data beats pushed by a credit-holding sender. There is no backpressure on the input side. Each beat popped at the output returns one credit to the sender as a single-cycle give pulse. Can optionally grant the full initial credit pool after reset or flush, for senders that reset with zero credits.

---
 rtl/credit_rx_storage.sv | 56 +++++
 rtl/credit_rx_buffer.sv | 80 ++++++++
 tb/tb_credit_rx_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/credit_rx_storage.sv
// Ring buffer behind the credit receiver: wrapping pointers, a beat counter,
// and a zero-masked head output. Depth does not have to be a power of two.
module credit_rx_storage #(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned Width = 32,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  usage_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else if (flush_i) begin
      // Stale contents stay in mem but are unreachable once usage is zero.
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_i) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      usage_q <= usage_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign valid_o = (usage_q != '0);
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign usage_o = usage_q;

endmodule

// File: rtl/credit_rx_buffer.sv
// Receiver side of a credit link: buffers pushed beats, returns one credit per
// popped beat, and can seed the sender with the whole pool after reset/flush.
module credit_rx_buffer #(
  parameter  int unsigned NumCredits      = 4,
  parameter  int unsigned DataWidth       = 32,
  parameter  bit          InitCreditGrant = 1'b0,
  localparam int unsigned CntW            = $clog2(NumCredits) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 inp_valid_i,
  input  logic [DataWidth-1:0] inp_data_i,
  output logic                 oup_valid_o,
  output logic [DataWidth-1:0] oup_data_o,
  input  logic                 oup_ready_i,
  output logic                 credit_give_o,
  output logic [CntW-1:0]      usage_o,
  output logic                 overflow_o
);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t PendInit = InitCreditGrant ? cnt_t'(NumCredits) : '0;

  logic pop;
  logic push_ok;
  logic overflow_q;
  cnt_t pend_q;
  cnt_t usage;

  assign pop     = oup_valid_o & oup_ready_i;
  // A full buffer still takes a beat when the head leaves in the same cycle.
  assign push_ok = inp_valid_i & ((usage != cnt_t'(NumCredits)) | pop);

  credit_rx_storage #(
    .Depth (NumCredits),
    .Width (DataWidth)
  ) u_storage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_ok),
    .data_i  (inp_data_i),
    .pop_i   (pop),
    .valid_o (oup_valid_o),
    .data_o  (oup_data_o),
    .usage_o (usage)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      overflow_q <= 1'b0;
      pend_q     <= PendInit;
    end else begin
      if (inp_valid_i && !push_ok) begin
        overflow_q <= 1'b1;
      end
      pend_q <= pend_q + cnt_t'(pop) - cnt_t'(credit_give_o);
    end
  end

  assign credit_give_o = (pend_q != '0);
  assign usage_o       = usage;
  assign overflow_o    = overflow_q;

  // The pend+usage sum only stays bounded for credit-legal senders, so only
  // the counter range and underflow are enforced here.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!$isunknown(inp_valid_i))
        else $error("inp_valid_i unknown after reset");
      assert (pend_q <= cnt_t'(NumCredits))
        else $error("pending credit count out of range: %0d", pend_q);
      assert (!(credit_give_o && pend_q == '0))
        else $error("pending credit counter underflow");
    end
  end

endmodule

// File: tb/tb_credit_rx_buffer.sv
// Directed + random bench for credit_rx_buffer: two instances (with and
// without the initial credit grant) checked every cycle against a queue model.
module tb_credit_rx_buffer;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = $clog2(N) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          inp_valid_i;
  logic [DW-1:0] inp_data_i;
  logic          oup_ready_i;

  logic          v_g, v_n, g_g, g_n, o_g, o_n;
  logic [DW-1:0] d_g, d_n;
  logic [CW-1:0] u_g, u_n;

  always #5 clk_i = ~clk_i;

  credit_rx_buffer #(.NumCredits(N), .DataWidth(DW), .InitCreditGrant(1'b1)) dut_g (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .inp_valid_i(inp_valid_i), .inp_data_i(inp_data_i),
    .oup_valid_o(v_g), .oup_data_o(d_g), .oup_ready_i(oup_ready_i),
    .credit_give_o(g_g), .usage_o(u_g), .overflow_o(o_g)
  );

  credit_rx_buffer #(.NumCredits(N), .DataWidth(DW), .InitCreditGrant(1'b0)) dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .inp_valid_i(inp_valid_i), .inp_data_i(inp_data_i),
    .oup_valid_o(v_n), .oup_data_o(d_n), .oup_ready_i(oup_ready_i),
    .credit_give_o(g_n), .usage_o(u_n), .overflow_o(o_n)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: beats in flight, sticky overflow, credits owed per instance.
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  int            pend_g, pend_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    pend_g = N;
    pend_n = 0;
  endtask

  task automatic check_outputs();
    logic          ev;
    logic [DW-1:0] ed;
    ev = (mq.size() != 0);
    ed = ev ? mq[0] : '0;
    chk("valid_g", v_g, ev);
    chk("valid_n", v_n, ev);
    chk("data_g", d_g, ed);
    chk("data_n", d_n, ed);
    chk("usage_g", u_g, mq.size());
    chk("usage_n", u_n, mq.size());
    chk("overflow_g", o_g, m_ovf);
    chk("overflow_n", o_n, m_ovf);
    chk("give_g", g_g, pend_g != 0);
    chk("give_n", g_n, pend_n != 0);
  endtask

  task automatic model_step();
    bit pop, acc;
    if (!rst_ni || flush_i) begin
      model_reset();
    end else begin
      pop = (mq.size() != 0) && oup_ready_i;
      acc = inp_valid_i && ((mq.size() < N) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(inp_data_i);
      else if (inp_valid_i) m_ovf = 1'b1;
      pend_g = pend_g + int'(pop) - int'(pend_g != 0);
      pend_n = pend_n + int'(pop) - int'(pend_n != 0);
    end
  endtask

  task automatic tick(input bit rst, input bit fl, input bit push,
                      input logic [DW-1:0] data, input bit rdy);
    rst_ni      = rst;
    flush_i     = fl;
    inp_valid_i = push;
    inp_data_i  = data;
    oup_ready_i = rdy;
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  int gives;

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; inp_valid_i = 1'b0;
    inp_data_i = '0; oup_ready_i = 1'b0;
    @(posedge clk_i);
    model_reset();
    #1;
    tick(0, 0, 0, '0, 0);

    // Initial grant: exactly N pulses on the granting instance.
    gives = 0;
    for (int i = 0; i < 6; i++) begin
      gives += int'(g_g);
      tick(1, 0, 0, '0, 0);
    end
    chk("init_grant_count", gives, N);

    // Two beats buffered, then drained in order.
    tick(1, 0, 1, 32'hA1, 0);
    tick(1, 0, 1, 32'hB2, 0);
    tick(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, '0, 1);

    // Fill, overflow with 0xEE, observe stickiness, then flush.
    for (int i = 0; i < N; i++) tick(1, 0, 1, 32'h10 + i, 0);
    tick(1, 0, 1, 32'hEE, 0);
    tick(1, 0, 0, '0, 0);
    tick(1, 0, 0, '0, 0);
    chk("overflow_sticky", o_g, 1'b1);
    chk("usage_full", u_g, N);
    tick(1, 1, 0, '0, 0);
    chk("overflow_flushed", o_n, 1'b0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, '0, 0);

    // Full buffer: push and pop in the same cycle is accepted.
    for (int i = 0; i < N; i++) tick(1, 0, 1, 32'h20 + i, 0);
    tick(1, 0, 1, 32'h55, 1);
    chk("full_pushpop_usage", u_n, N);
    chk("full_pushpop_ovf", o_n, 1'b0);
    for (int i = 0; i < N + 2; i++) tick(1, 0, 0, '0, 1);

    // Flush with concurrent push and pop while credits are pending.
    tick(1, 0, 1, 32'h31, 0);
    tick(1, 0, 1, 32'h32, 0);
    tick(1, 0, 1, 32'h33, 0);
    tick(1, 0, 1, 32'h34, 1);
    tick(1, 0, 1, 32'h35, 1);
    tick(1, 1, 1, 32'h36, 1);
    gives = 0;
    for (int i = 0; i < 6; i++) begin
      gives += int'(g_n);
      tick(1, 0, 0, '0, 0);
    end
    chk("flush_no_credit", gives, 0);

    // Sustained push+pop: usage stays put, a credit every cycle.
    tick(1, 0, 1, 32'h40, 0);
    for (int i = 0; i < 20; i++) tick(1, 0, 1, $urandom, 1);
    chk("sustained_give", g_n, 1'b1);
    chk("sustained_usage", u_n, 1);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, '0, 1);

    // Random traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      tick(i != 150, $urandom_range(31) == 0, $urandom_range(1) == 1,
           $urandom, $urandom_range(3) != 0);
    end
    tick(1, 0, 0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
